key_debounce_9: RTL and testbench
=================================

# key_debounce_9

Debounce front end for the 9-line active-low priority encoder. It synchronises 9 raw active-low key or request lines and filters contact bounce with one saturating counter per line. It drives the encoder's 9-bit `I_n` bus with clean, stable levels and emits one-cycle press and release strobes per line. It sits directly upstream of the encoder; `key_db_n` connects bit-for-bit to `I_n`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16'd50000: consecutive cycles a new level must persist before it is accepted. Legal range is 2 to 2^CNT_W−1.
- `CNT_W`, 16: width of each per-line counter.

Ports:
- `clk`  input  1: single clock; all state on rising edge.
- `rst_n`  input  1: asynchronous active-low reset, one clock domain.
- `key_raw_n`  input  9: raw lines, asynchronous to `clk`, active-low (0 = pressed).
- `key_db_n`  output  9: debounced levels, active-low, registered; feeds encoder `I_n`.
- `press_p`  output  9: one-cycle pulse when `key_db_n[i]` goes 1→0.
- `release_p`  output  9: one-cycle pulse when `key_db_n[i]` goes 0→1.
- `any_db`  output  1: registered OR of pressed lines, i.e. `~&key_db_n` of the next state; high while any line is debounced-pressed.

## Operation
- Lines are fully independent. Each line i has a sampled level `s[i]`, a stable level `key_db_n[i]` and a counter `cnt[i]`.
- Each line behaves identically every cycle:
  - If `s[i] == key_db_n[i]`: `cnt[i]` ← 0.
  - Else, if `cnt[i] == DEBOUNCE_CYCLES−1`: `key_db_n[i]` ← `s[i]`, `cnt[i]` ← 0, and the matching strobe is asserted for exactly that next cycle.
  - Else: `cnt[i]` ← `cnt[i]`+1.
- A single mismatch-free cycle, i.e. a bounce back to the stable level, restarts the count from 0. Partial counts are never retained.
- `press_p`/`release_p` are high only in the cycle after `key_db_n` changes. They are never both high on the same line. Multiple lines may strobe in the same cycle.
- The counter never exceeds `DEBOUNCE_CYCLES−1`, so no wrap-around is possible.
- Reset values:
  - `key_db_n` = 9'h1FF
  - `press_p` = 0, `release_p` = 0
  - `any_db` = 0
  - all `cnt` = 0
  - synchroniser flops = 1 (idle released)
- Reset mid-operation clears all state immediately. Lines held low through reset release are re-debounced from zero and then produce a normal `press_p`.

## Timing
- Let edge 1 be the first rising edge that samples a new raw level, and let the level stay constant.
  - With synchroniser (see Configuration): `key_db_n[i]` changes on edge `DEBOUNCE_CYCLES`+2. The strobe is high from that edge to the next.
  - Without synchroniser: `key_db_n[i]` changes on edge `DEBOUNCE_CYCLES`.
- A pulse shorter than `DEBOUNCE_CYCLES` sampled cycles never reaches `key_db_n`.
- `any_db` updates on the same edge as `key_db_n`.
- There is no combinational path from input to output.

## Configuration
- `KEY_SYNC2_EN` defined: `s[i]` is the output of a 2-flop synchroniser on `key_raw_n[i]`, reset to 1. Use this when the lines are truly asynchronous.
- `KEY_SYNC2_EN` undefined: `s[i]` = `key_raw_n[i]` directly, and latency is reduced by 2 cycles. Use this only when the lines are already synchronous to `clk`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `CNT_W`=3, with `KEY_SYNC2_EN` defined unless noted.
- Reset check: assert `rst_n`=0 with `key_raw_n`=9'h1FE, then release. Required: `key_db_n`=9'h1FF during reset; after release, `key_db_n[0]`→0 on edge 6; `press_p`=9'h001 for one cycle; `any_db`=1.
- Bounce rejection: `key_raw_n[5]` toggles 0/1 with 3-cycle low, 1-cycle high, repeated 5 times, then stays low. Required: no change during bouncing; `key_db_n[5]`=0 exactly 6 edges after the final steady low is first sampled.
- Glitch: drive a 3-cycle low pulse on `key_raw_n[8]`. Required: `key_db_n`, `press_p` and `any_db` never change.
- Simultaneous lines: `key_raw_n` goes from 9'h1FF to 9'h0F6 in one cycle. Required: `key_db_n`=9'h0F6 and `press_p`=9'h109 on the same edge. Releasing to 9'h1FF later gives `release_p`=9'h109 for one cycle and `any_db`→0.
- Macro off: rerun the glitch and bounce-rejection scenarios without `KEY_SYNC2_EN`. Required: identical behaviour, with the output edge 2 cycles earlier, i.e. edge 4.
- Encoder integration: connect `key_db_n` to the encoder `I_n` and press lines 3 and 6. Required: encoder `Y_n`=4'b1000 once both are debounced.

Source files
------------

// File: rtl/key_debounce_9.sv
// rtl/key_debounce_9.sv - 9-line active-low key debouncer feeding the priority encoder I_n bus
// Optional feature macro: KEY_SYNC2_EN (2-flop input synchroniser on every raw line)
module key_debounce_9 #(
    parameter int unsigned          CNT_W           = 16,
    parameter logic [CNT_W-1:0]     DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] key_raw_n,
    output logic [8:0] key_db_n,
    output logic [8:0] press_p,
    output logic [8:0] release_p,
    output logic       any_db
);

    // Terminal count: a mismatch seen with the counter here is the last one needed.
    localparam logic [CNT_W-1:0] CNT_MAX = DEBOUNCE_CYCLES - 1'b1;

    logic [8:0]       s;
    logic [8:0]       db_nxt;
    logic [CNT_W-1:0] cnt     [9];
    logic [CNT_W-1:0] cnt_nxt [9];

`ifdef KEY_SYNC2_EN
    logic [8:0] sync1;
    logic [8:0] sync2;

    // Two-flop synchroniser; resets to the released (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_raw_n;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = key_raw_n;
`endif

    // Per-line filter: count consecutive mismatches, accept the new level on the last one,
    // and restart from zero on any cycle that matches the stable level.
    always_comb begin
        db_nxt = key_db_n;
        for (int i = 0; i < 9; i++) begin
            cnt_nxt[i] = '0;
            if (s[i] != key_db_n[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    db_nxt[i] = s[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Register stable levels, counters and the edge strobes derived from the level change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_db_n  <= '1;
            press_p   <= '0;
            release_p <= '0;
            any_db    <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            key_db_n  <= db_nxt;
            press_p   <= key_db_n & ~db_nxt;
            release_p <= ~key_db_n & db_nxt;
            any_db    <= ~&db_nxt;
            for (int i = 0; i < 9; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_key_debounce_9.sv
// tb/tb_key_debounce_9.sv - scoreboard bench for key_debounce_9 with a history-window reference model
module tb_key_debounce_9;

    localparam int D = 4;
`ifdef KEY_SYNC2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] key_raw_n;
    logic [8:0] key_db_n;
    logic [8:0] press_p;
    logic [8:0] release_p;
    logic       any_db;

    key_debounce_9 #(.CNT_W(3), .DEBOUNCE_CYCLES(3'd4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_raw_n (key_raw_n),
        .key_db_n  (key_db_n),
        .press_p   (press_p),
        .release_p (release_p),
        .any_db    (any_db)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] db;
        logic [8:0] pr;
        logic [8:0] rl;
        logic       an;
    } exp_t;

    exp_t       exp_q [$];
    logic [8:0] raw_q [$];
    logic [8:0] s_q   [$];
    logic [8:0] m_db;
    int         n_cmp  = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Reference: a line flips once its last D sampled values all differ from its stable level.
    task automatic model_edge(input logic [8:0] raw, input logic rstn);
        exp_t       e;
        logic [8:0] s;
        logic [8:0] nd;
        logic       all_diff;
        if (!rstn) begin
            raw_q.delete();
            s_q.delete();
            m_db = 9'h1FF;
            e.db = 9'h1FF; e.pr = '0; e.rl = '0; e.an = 1'b0;
        end else begin
            raw_q.push_back(raw);
            if (raw_q.size() > 3) void'(raw_q.pop_front());
            s = (raw_q.size() > LAT) ? raw_q[raw_q.size()-1-LAT] : 9'h1FF;
            s_q.push_back(s);
            if (s_q.size() > D) void'(s_q.pop_front());
            nd = m_db;
            for (int i = 0; i < 9; i++) begin
                all_diff = (s_q.size() == D);
                foreach (s_q[j]) if (s_q[j][i] == m_db[i]) all_diff = 1'b0;
                if (all_diff) nd[i] = ~m_db[i];
            end
            e.db = nd;
            e.pr = m_db & ~nd;
            e.rl = ~m_db & nd;
            e.an = (nd != 9'h1FF);
            m_db = nd;
        end
        exp_q.push_back(e);
    endtask

    // Drive one clock's worth of input, queue its expected result, return after the edge is checked.
    task automatic step(input logic [8:0] raw, input logic rstn);
        key_raw_n = raw;
        rst_n     = rstn;
        model_edge(raw, rstn);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic hold(input logic [8:0] raw, input int n);
        for (int k = 0; k < n; k++) step(raw, 1'b1);
    endtask

    // Monitor: compare the outputs of every edge against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("key_db_n",  key_db_n,  e.db);
                chk("press_p",   press_p,   e.pr);
                chk("release_p", release_p, e.rl);
                chk("any_db",    {8'b0, any_db}, {8'b0, e.an});
            end
        end
    end

    initial begin
        logic [8:0] cur;
        int         first;
        m_db      = 9'h1FF;
        rst_n     = 1'b0;
        key_raw_n = 9'h1FF;
        @(negedge clk);
        #1;

        // Reset held with line 0 pressed, then measure edges to acceptance.
        for (int k = 0; k < 3; k++) step(9'h1FE, 1'b0);
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            step(9'h1FE, 1'b1);
            if (first < 0 && key_db_n[0] == 1'b0) first = k;
        end
        chk("press_latency", first[8:0], 9'(LAT + D));
        hold(9'h1FF, 10);

        // Glitch shorter than D on line 8.
        hold(9'h0FF, 3);
        hold(9'h1FF, 10);

        // Bounce on line 5, then steady low; measure edges from first steady sample.
        for (int r = 0; r < 5; r++) begin
            hold(9'h1DF, 3);
            hold(9'h1FF, 1);
        end
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            step(9'h1DF, 1'b1);
            if (first < 0 && key_db_n[5] == 1'b0) first = k;
        end
        chk("bounce_latency", first[8:0], 9'(LAT + D));
        hold(9'h1FF, 10);

        // Several lines change together.
        hold(9'h0F6, 10);
        hold(9'h1FF, 10);

        // Reset in the middle of activity.
        hold(9'h055, 8);
        step(9'h055, 1'b0);
        step(9'h055, 1'b0);
        hold(9'h055, 10);
        hold(9'h1FF, 10);

        // Randomised bouncing lines with occasional resets.
        cur = 9'h1FF;
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 9; i++)
                if ($urandom_range(0, 5) == 0) cur[i] = ~cur[i];
            step(cur, ($urandom_range(0, 599) != 0));
        end
        hold(9'h1FF, 10);

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        chk("queue_drained", 9'(exp_q.size()), 9'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
